// File: rtl/encoder_8_3_queued_pkg.sv
// Shared constants and types for the queued 8-to-3 encoder.
// Also holds the fixed-priority helper that the arbiter uses when round-robin is off.
package enc_pkg;
    localparam int N_IN   = 8;
    localparam int CODE_W = $clog2(N_IN);

    typedef logic [N_IN-1:0]   req_vec_t;
    typedef logic [CODE_W-1:0] code_t;

    // The valid flag is the only state: IDLE = nothing presented, HOLD = code_o valid.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } enc_state_t;

    // Returns the index of the highest set bit. An all-zero input returns 0.
    function automatic code_t highest_set(input req_vec_t v);
        code_t c;
        c = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (v[i]) c = code_t'(i);
        end
        return c;
    endfunction
endpackage

// File: rtl/encoder_8_3_queued_rr_pick.sv
// Round-robin picker: selects the first pending bit at or above ptr, wrapping past N_IN-1.
// It stacks the full vector above the masked copy, so one lowest-bit scan covers the wrap.
import enc_pkg::*;

module rr_pick (
    input  logic [N_IN-1:0]   pending,
    input  logic [CODE_W-1:0] ptr,
    output logic [CODE_W-1:0] sel,
    output logic              any
);
    logic [N_IN-1:0]   upper_mask;
    logic [2*N_IN-1:0] dbl;

    always_comb begin
        upper_mask = ~((req_vec_t'(1) << ptr) - req_vec_t'(1));
        dbl        = {pending, pending & upper_mask};
        sel        = '0;
        // Scan downward, so the lowest set bit is the one that lands in sel.
        for (int i = 2*N_IN-1; i >= 0; i--) begin
            if (dbl[i]) sel = code_t'(i);
        end
        any = |pending;
    end
endmodule

// File: rtl/encoder_8_3_queued.sv
// Queued 8-to-3 encoder: it collects request events in a pending register.
// It sends out one binary code for each grant over a valid/ready handshake.
import enc_pkg::*;

module encoder_8_3_queued #(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              E,
    input  logic [N_IN-1:0]   req_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [CODE_W-1:0] code_o,
    output logic [N_IN-1:0]   pend_o,
    output logic              ovf_o,
    input  logic              ovf_clr_i
);
    // Handshake: a code transfers on any rising edge where valid_o && ready_i.
    // While valid_o=1 and ready_i=0, code_o and valid_o hold stable.
    // valid_o never drops without a transfer, except on reset.
    enc_state_t state_q, state_d;
    req_vec_t   pending_q, pending_d, req_in, grant_mask;
    code_t      code_q, ptr_q, rr_sel, fp_sel, sel;
    logic       any, load, ovf_q, ovf_set;

    rr_pick u_rr_pick (
        .pending (pending_q),
        .ptr     (ptr_q),
        .sel     (rr_sel),
        .any     (any)
    );

    always_comb begin
        fp_sel     = highest_set(pending_q);
        sel        = RR_EN ? rr_sel : fp_sel;
        load       = ((state_q == ST_IDLE) || ready_i) && any;
        grant_mask = load ? (req_vec_t'(1) << sel) : '0;
        req_in     = E ? req_i : '0;
        // A new request on the bit being granted wins and stays pending.
        pending_d  = (pending_q & ~grant_mask) | req_in;
        ovf_set    = |(req_in & pending_q & ~grant_mask);
        state_d    = state_q;
        if ((state_q == ST_IDLE) || ready_i) begin
            state_d = load ? ST_HOLD : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            code_q    <= '0;
            ptr_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (load) begin
                code_q <= sel;
                if (RR_EN) ptr_q <= sel + 1'b1;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign valid_o = (state_q == ST_HOLD);
    assign code_o  = code_q;
    assign pend_o  = pending_q;
    assign ovf_o   = ovf_q;
endmodule

// File: tb/tb_encoder_8_3_queued.sv
// Directed bench with two instances, round-robin and fixed priority, sharing one stimulus.
// Each instance has its own expected-code queue, which a negedge monitor drains on every handshake.
import enc_pkg::*;

module tb_encoder_8_3_queued;
    logic              clk = 1'b0;
    logic              rst_n, e, ready, ovf_clr;
    logic [N_IN-1:0]   req;
    logic              valid_rr, valid_fp, ovf_rr, ovf_fp;
    logic [CODE_W-1:0] code_rr, code_fp;
    logic [N_IN-1:0]   pend_rr, pend_fp;

    logic [CODE_W-1:0] exp_rr[$];
    logic [CODE_W-1:0] exp_fp[$];
    int n_cmp = 0;
    int n_mis = 0;

    encoder_8_3_queued #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .E(e), .req_i(req), .ready_i(ready),
        .valid_o(valid_rr), .code_o(code_rr), .pend_o(pend_rr),
        .ovf_o(ovf_rr), .ovf_clr_i(ovf_clr)
    );

    encoder_8_3_queued #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .E(e), .req_i(req), .ready_i(ready),
        .valid_o(valid_fp), .code_o(code_fp), .pend_o(pend_fp),
        .ovf_o(ovf_fp), .ovf_clr_i(ovf_clr)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [N_IN-1:0] r, input int n);
        req = r;
        repeat (n) tick();
        req = '0;
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (exp_rr.size() == 0 && exp_fp.size() == 0 && !valid_rr && !valid_fp) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_drain"}, 32'(done), 32'd1);
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        if (rst_n && valid_rr && ready) begin
            if (exp_rr.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL rr_unexpected: got code %0d with nothing expected at %0t", code_rr, $time);
            end else begin
                check("rr_code", 32'(code_rr), 32'(exp_rr.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid_fp && ready) begin
            if (exp_fp.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL fp_unexpected: got code %0d with nothing expected at %0t", code_fp, $time);
            end else begin
                check("fp_code", 32'(code_fp), 32'(exp_fp.pop_front()));
            end
        end
    end

    // stimulus
    initial begin
        rst_n = 1'b0; e = 1'b1; req = 8'hFF; ready = 1'b1; ovf_clr = 1'b0;
        tick();
        tick();
        check("rst_valid_rr", 32'(valid_rr), 32'd0);
        check("rst_valid_fp", 32'(valid_fp), 32'd0);
        check("rst_pend_rr", 32'(pend_rr), 32'h0);
        check("rst_pend_fp", 32'(pend_fp), 32'h0);
        check("rst_ovf_rr", 32'(ovf_rr), 32'd0);
        check("rst_code_rr", 32'(code_rr), 32'd0);

        // Release reset with all requests up: everything drains in one pass.
        rst_n = 1'b1;
        tick();
        check("rel_pend_rr", 32'(pend_rr), 32'hFF);
        check("rel_pend_fp", 32'(pend_fp), 32'hFF);
        check("rel_valid_rr", 32'(valid_rr), 32'd0);
        req = '0;
        for (int i = 0; i < 8; i++) begin
            exp_rr.push_back(CODE_W'(i));
            exp_fp.push_back(CODE_W'(7 - i));
        end
        wait_idle("all8");

        // Round robin starting from ptr 0; the second pass checks the 7 -> 0 wrap.
        for (int pass = 0; pass < 2; pass++) begin
            exp_rr.push_back(3'd0); exp_rr.push_back(3'd7);
            exp_fp.push_back(3'd7); exp_fp.push_back(3'd0);
            drive_req(8'h81, 1);
            wait_idle("rr81");
        end

        // Single event: code appears two edges after the request.
        exp_rr.push_back(3'd5); exp_fp.push_back(3'd5);
        req = 8'h20;
        tick();
        req = '0;
        check("single_pend", 32'(pend_rr), 32'h20);
        check("single_valid0", 32'(valid_rr), 32'd0);
        tick();
        check("single_valid1", 32'(valid_rr), 32'd1);
        check("single_code", 32'(code_rr), 32'd5);
        check("single_pend0", 32'(pend_rr), 32'h0);
        tick();
        check("single_idle", 32'(valid_rr), 32'd0);
        check("single_code_hold", 32'(code_rr), 32'd5);

        // Fixed priority gives 3 then 2; round robin from ptr 6 wraps to 2 then 3.
        exp_rr.push_back(3'd2); exp_rr.push_back(3'd3);
        exp_fp.push_back(3'd3); exp_fp.push_back(3'd2);
        drive_req(8'h0C, 1);
        wait_idle("prio0C");

        // Stall with a repeated request: overflow on the third clock.
        ready = 1'b0;
        drive_req(8'h02, 3);
        check("stall_valid", 32'(valid_rr), 32'd1);
        check("stall_code_rr", 32'(code_rr), 32'd1);
        check("stall_code_fp", 32'(code_fp), 32'd1);
        check("stall_ovf_rr", 32'(ovf_rr), 32'd1);
        check("stall_ovf_fp", 32'(ovf_fp), 32'd1);
        check("stall_pend", 32'(pend_rr), 32'h02);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr_ovf_rr", 32'(ovf_rr), 32'd0);
        check("clr_ovf_fp", 32'(ovf_fp), 32'd0);
        check("clr_code_hold", 32'(code_rr), 32'd1);
        check("clr_valid_hold", 32'(valid_rr), 32'd1);
        exp_rr.push_back(3'd1); exp_rr.push_back(3'd1);
        exp_fp.push_back(3'd1); exp_fp.push_back(3'd1);
        ready = 1'b1;
        wait_idle("stall");

        // Enable gating: with E=0, pending does not change while stalled.
        ready = 1'b0;
        drive_req(8'h18, 1);
        tick();
        e = 1'b0;
        req = 8'hFF;
        tick();
        tick();
        check("gate_pend_rr", 32'(pend_rr), 32'h10);
        check("gate_pend_fp", 32'(pend_fp), 32'h08);
        check("gate_code_rr", 32'(code_rr), 32'd3);
        check("gate_code_fp", 32'(code_fp), 32'd4);
        check("gate_ovf", 32'(ovf_rr), 32'd0);
        e = 1'b1;
        req = '0;
        exp_rr.push_back(3'd3); exp_rr.push_back(3'd4);
        exp_fp.push_back(3'd4); exp_fp.push_back(3'd3);
        ready = 1'b1;
        wait_idle("gate");

        // A request on the bit granted in the same cycle stays pending and is granted again.
        exp_rr.push_back(3'd2); exp_rr.push_back(3'd2);
        exp_fp.push_back(3'd2); exp_fp.push_back(3'd2);
        req = 8'h04;
        tick();
        tick();
        check("same_pend", 32'(pend_rr), 32'h04);
        check("same_valid", 32'(valid_rr), 32'd1);
        check("same_code", 32'(code_fp), 32'd2);
        check("same_ovf", 32'(ovf_rr), 32'd0);
        req = '0;
        wait_idle("same");

        // A reset during a stalled handshake drops the in-flight code.
        ready = 1'b0;
        drive_req(8'h01, 1);
        tick();
        check("mid_valid", 32'(valid_rr), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid_rr", 32'(valid_rr), 32'd0);
        check("mid_rst_valid_fp", 32'(valid_fp), 32'd0);
        check("mid_rst_pend", 32'(pend_rr), 32'h0);
        check("mid_rst_code", 32'(code_rr), 32'd0);
        rst_n = 1'b1;
        tick();
        check("mid_after_valid", 32'(valid_rr), 32'd0);

        check("rr_queue_empty", 32'(exp_rr.size()), 32'd0);
        check("fp_queue_empty", 32'(exp_fp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
